// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with optional write-to-read bypass and an
// integrated pending-write scoreboard for RAW/WAW hazard detection at issue.
module regfile_mp_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_dout,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]  wr_din,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_addr,
  output logic                     iss_ok,
  input  logic                     flush,
  output logic [DEPTH-1:0]         pend
);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pend_nxt;

  logic [AW-1:0]    wa [NUM_WR];
  logic [WIDTH-1:0] wd [NUM_WR];
  logic [AW-1:0]    ra [NUM_RD];
  logic [NUM_WR-1:0] wr_acc;

  logic iss_zero;
  logic iss_in;
  logic iss_pend;
  logic iss_wr_hit;
  logic iss_mark;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign wa[k] = wr_addr[k*AW +: AW];
    assign wd[k] = wr_din[k*WIDTH +: WIDTH];
    assign wr_acc[k] = rst && we[k] && in_range(wa[k]) && !is_zero_reg(wa[k]);
  end

  // Read ports: later write ports override earlier ones on a bypass match,
  // mirroring the storage priority so bypass and stored data always agree.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic             hit;
    logic [WIDTH-1:0] bdata;
    logic [WIDTH-1:0] dout;
    logic             busy;

    assign ra[i] = rd_addr[i*AW +: AW];

    always_comb begin
      hit   = 1'b0;
      bdata = '0;
      for (int k = 0; k < NUM_WR; k++) begin
        if ((BYPASS != 0) && wr_acc[k] && (wa[k] == ra[i])) begin
          hit   = 1'b1;
          bdata = wd[k];
        end
      end
    end

    always_comb begin
      dout = '0;
      busy = 1'b0;
      if (in_range(ra[i]) && !is_zero_reg(ra[i])) begin
        dout = hit ? bdata : mem[ra[i]];
        busy = pending[ra[i]] && !hit;
      end
    end

    assign rd_dout[i*WIDTH +: WIDTH] = dout;
    assign rd_busy[i]                = busy;
  end

  // Issue acceptance: a pending destination may be reissued when its
  // writeback lands in the same cycle.
  always_comb begin
    iss_zero   = is_zero_reg(iss_addr);
    iss_in     = in_range(iss_addr);
    iss_pend   = iss_in ? pending[iss_addr] : 1'b0;
    iss_wr_hit = 1'b0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_acc[k] && (wa[k] == iss_addr)) iss_wr_hit = 1'b1;
    end
  end

  assign iss_ok   = rst && iss_valid && !flush && (iss_zero || !iss_pend || iss_wr_hit);
  assign iss_mark = iss_ok && !iss_zero && iss_in;

  // The issue set is applied after write clears so it wins on the same bit.
  always_comb begin
    pend_nxt = pending;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_acc[k]) pend_nxt[wa[k]] = 1'b0;
    end
    if (iss_mark) pend_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
      for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_acc[k]) mem[wa[k]] <= wd[k];
      end
      pending <= flush ? '0 : pend_nxt;
    end
  end

  assign pend = pending;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: one bypassing and one non-bypassing
// instance share the same stimulus.
module tb_regfile_mp_sb;
  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_dout, rd_dout_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic [1:0]  we;
  logic [9:0]  wr_addr;
  logic [63:0] wr_din;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ok, iss_ok_nb;
  logic        flush;
  logic [31:0] pend, pend_nb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_mp_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(rd_dout), .rd_busy(rd_busy),
    .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .iss_ok(iss_ok), .flush(flush), .pend(pend)
  );

  regfile_mp_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(rd_dout_nb), .rd_busy(rd_busy_nb),
    .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .iss_ok(iss_ok_nb), .flush(flush), .pend(pend_nb)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we = 2'b00; wr_addr = '0; wr_din = '0;
    iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; rd_addr = {5'd6, 5'd5}; idle();
    tick(); tick();
    rst = 1'b1;
    #4;
    vectors++; if (pend !== 32'h0) begin $display("FAIL reset_pend: got %h expected %h", pend, 32'h0); miscompares++; end
    vectors++; if (rd_dout !== 64'h0) begin $display("FAIL reset_dout: got %h expected %h", rd_dout, 64'h0); miscompares++; end
    vectors++; if (rd_busy !== 2'b00) begin $display("FAIL reset_busy: got %b expected %b", rd_busy, 2'b00); miscompares++; end
    tick();
    we = 2'b01; wr_addr = {5'd0, 5'd5}; wr_din = {32'h0, 32'hDEADBEEF};
    tick(); idle();
    #4;
    vectors++; if (rd_dout[31:0] !== 32'hDEADBEEF) begin $display("FAIL pre_reset_x5: got %h expected %h", rd_dout[31:0], 32'hDEADBEEF); miscompares++; end
    tick();
    rst = 1'b0; we = 2'b01; wr_addr = {5'd0, 5'd6}; wr_din = {32'h0, 32'h11111111};
    iss_valid = 1'b1; iss_addr = 5'd8;
    #4;
    vectors++; if (iss_ok !== 1'b0) begin $display("FAIL reset_iss_ok: got %b expected %b", iss_ok, 1'b0); miscompares++; end
    tick();
    rst = 1'b1; idle();
    #4;
    vectors++; if (rd_dout[31:0] !== 32'h0) begin $display("FAIL reset_x5_cleared: got %h expected %h", rd_dout[31:0], 32'h0); miscompares++; end
    vectors++; if (rd_dout[63:32] !== 32'h0) begin $display("FAIL reset_write_ignored: got %h expected %h", rd_dout[63:32], 32'h0); miscompares++; end
    vectors++; if (pend !== 32'h0) begin $display("FAIL reset_issue_ignored: got %h expected %h", pend, 32'h0); miscompares++; end
    tick();
  endtask

  task automatic test_zero_reg;
    we = 2'b01; wr_addr = {5'd0, 5'd0}; wr_din = {32'h0, 32'h12345678};
    iss_valid = 1'b1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    #4;
    vectors++; if (rd_dout[31:0] !== 32'h0) begin $display("FAIL x0_bypass: got %h expected %h", rd_dout[31:0], 32'h0); miscompares++; end
    vectors++; if (iss_ok !== 1'b1) begin $display("FAIL x0_iss_ok: got %b expected %b", iss_ok, 1'b1); miscompares++; end
    tick(); idle();
    #4;
    vectors++; if (pend[0] !== 1'b0) begin $display("FAIL x0_pend: got %b expected %b", pend[0], 1'b0); miscompares++; end
    vectors++; if (rd_dout !== 64'h0) begin $display("FAIL x0_stored: got %h expected %h", rd_dout, 64'h0); miscompares++; end
    tick();
  endtask

  task automatic test_bypass_conflict;
    we = 2'b11; wr_addr = {5'd7, 5'd7}; wr_din = {32'h5555, 32'hAAAA};
    rd_addr = {5'd7, 5'd7};
    #4;
    vectors++; if (rd_dout !== {32'h5555, 32'h5555}) begin $display("FAIL bypass_same_cycle: got %h expected %h", rd_dout, {32'h5555, 32'h5555}); miscompares++; end
    vectors++; if (rd_dout_nb !== 64'h0) begin $display("FAIL nobypass_same_cycle: got %h expected %h", rd_dout_nb, 64'h0); miscompares++; end
    tick(); idle();
    #4;
    vectors++; if (rd_dout !== {32'h5555, 32'h5555}) begin $display("FAIL bypass_next_cycle: got %h expected %h", rd_dout, {32'h5555, 32'h5555}); miscompares++; end
    vectors++; if (rd_dout_nb !== {32'h5555, 32'h5555}) begin $display("FAIL nobypass_next_cycle: got %h expected %h", rd_dout_nb, {32'h5555, 32'h5555}); miscompares++; end
    tick();
  endtask

  task automatic test_scoreboard;
    iss_valid = 1'b1; iss_addr = 5'd3; rd_addr = {5'd7, 5'd3};
    #4;
    vectors++; if (iss_ok !== 1'b1) begin $display("FAIL sb_iss_ok: got %b expected %b", iss_ok, 1'b1); miscompares++; end
    tick();
    #4;
    vectors++; if (pend !== 32'h8) begin $display("FAIL sb_pend_set: got %h expected %h", pend, 32'h8); miscompares++; end
    vectors++; if (rd_busy !== 2'b01) begin $display("FAIL sb_busy: got %b expected %b", rd_busy, 2'b01); miscompares++; end
    vectors++; if (iss_ok !== 1'b0) begin $display("FAIL sb_reissue: got %b expected %b", iss_ok, 1'b0); miscompares++; end
    tick(); idle();
    #4;
    vectors++; if (pend !== 32'h8) begin $display("FAIL sb_reject_no_change: got %h expected %h", pend, 32'h8); miscompares++; end
    tick();
    we = 2'b01; wr_addr = {5'd0, 5'd3}; wr_din = {32'h0, 32'h42}; rd_addr = {5'd3, 5'd3};
    #4;
    vectors++; if (rd_busy !== 2'b00) begin $display("FAIL sb_wb_busy: got %b expected %b", rd_busy, 2'b00); miscompares++; end
    vectors++; if (rd_dout[31:0] !== 32'h42) begin $display("FAIL sb_wb_dout: got %h expected %h", rd_dout[31:0], 32'h42); miscompares++; end
    vectors++; if (rd_busy_nb !== 2'b11) begin $display("FAIL sb_wb_busy_nobypass: got %b expected %b", rd_busy_nb, 2'b11); miscompares++; end
    tick(); idle();
    #4;
    vectors++; if (pend !== 32'h0) begin $display("FAIL sb_pend_clear: got %h expected %h", pend, 32'h0); miscompares++; end
    vectors++; if (rd_dout_nb[31:0] !== 32'h42) begin $display("FAIL sb_stored_x3: got %h expected %h", rd_dout_nb[31:0], 32'h42); miscompares++; end
    tick();
  endtask

  task automatic test_issue_with_writeback;
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick(); idle();
    #4;
    vectors++; if (pend !== 32'h200) begin $display("FAIL iwb_pend_before: got %h expected %h", pend, 32'h200); miscompares++; end
    tick();
    iss_valid = 1'b1; iss_addr = 5'd9;
    we = 2'b10; wr_addr = {5'd9, 5'd0}; wr_din = {32'h99, 32'h0};
    #4;
    vectors++; if (iss_ok !== 1'b1) begin $display("FAIL iwb_iss_ok: got %b expected %b", iss_ok, 1'b1); miscompares++; end
    tick(); idle(); rd_addr = {5'd9, 5'd9};
    #4;
    vectors++; if (pend !== 32'h200) begin $display("FAIL iwb_pend_kept: got %h expected %h", pend, 32'h200); miscompares++; end
    vectors++; if (rd_dout_nb !== {32'h99, 32'h99}) begin $display("FAIL iwb_mem: got %h expected %h", rd_dout_nb, {32'h99, 32'h99}); miscompares++; end
    tick();
    we = 2'b01; wr_addr = {5'd0, 5'd9}; wr_din = {32'h0, 32'h99};
    tick(); idle();
    #4;
    vectors++; if (pend !== 32'h0) begin $display("FAIL iwb_pend_clear: got %h expected %h", pend, 32'h0); miscompares++; end
    tick();
  endtask

  task automatic test_flush;
    iss_valid = 1'b1;
    iss_addr = 5'd1; tick();
    iss_addr = 5'd2; tick();
    iss_addr = 5'd4; tick();
    idle();
    #4;
    vectors++; if (pend !== 32'h16) begin $display("FAIL flush_pend_before: got %h expected %h", pend, 32'h16); miscompares++; end
    tick();
    flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd6;
    we = 2'b01; wr_addr = {5'd0, 5'd1}; wr_din = {32'h0, 32'h77};
    #4;
    vectors++; if (iss_ok !== 1'b0) begin $display("FAIL flush_iss_ok: got %b expected %b", iss_ok, 1'b0); miscompares++; end
    tick(); idle(); rd_addr = {5'd6, 5'd1};
    #4;
    vectors++; if (pend !== 32'h0) begin $display("FAIL flush_pend: got %h expected %h", pend, 32'h0); miscompares++; end
    vectors++; if (rd_dout_nb[31:0] !== 32'h77) begin $display("FAIL flush_write_kept: got %h expected %h", rd_dout_nb[31:0], 32'h77); miscompares++; end
    tick();
  endtask

  task automatic test_dual_write_ports;
    we = 2'b11; wr_addr = {5'd10, 5'd11}; wr_din = {32'hA0A0_0010, 32'hB0B0_0011};
    rd_addr = {5'd11, 5'd10};
    #4;
    vectors++; if (rd_dout !== {32'hB0B0_0011, 32'hA0A0_0010}) begin $display("FAIL dual_bypass: got %h expected %h", rd_dout, {32'hB0B0_0011, 32'hA0A0_0010}); miscompares++; end
    tick(); idle();
    #4;
    vectors++; if (rd_dout_nb !== {32'hB0B0_0011, 32'hA0A0_0010}) begin $display("FAIL dual_stored: got %h expected %h", rd_dout_nb, {32'hB0B0_0011, 32'hA0A0_0010}); miscompares++; end
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_bypass_conflict();
    test_scoreboard();
    test_issue_with_writeback();
    test_flush();
    test_dual_write_ports();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
